// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS controller.
// MC_CTRL_MEM_WAIT_EN enables the memory wait-state handshake.
package mc_ctrl_pkg;

`ifdef MC_CTRL_MEM_WAIT_EN
  localparam bit MEM_WAIT_EN = 1'b1;
`else
  localparam bit MEM_WAIT_EN = 1'b0;
`endif

  typedef enum logic [4:0] {
    S_RESET, S_IF, S_ID, S_EX_LS, S_MEM_RD, S_WB_LS, S_MEM_ST, S_EX_R, S_WB_R,
    S_BEQ, S_BNE, S_J, S_JAL_WB, S_JR, S_EX_ADDI, S_EX_ANDI, S_EX_ORI,
    S_EX_SLTI, S_EX_LUI, S_WB_I, S_TRAP
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_FUNCT = 3'b010,
                         ALU_OR  = 3'b011, ALU_AND = 3'b100, ALU_SLT   = 3'b101,
                         ALU_LUI = 3'b110;
  localparam logic [2:0] PC_ALU = 3'b000, PC_ALUOUT = 3'b001, PC_JUMP = 3'b010,
                         PC_REGA = 3'b011, PC_RSTV = 3'b100;
  localparam logic [1:0] RD_RT = 2'b00, RD_RD = 2'b01, RD_RA = 2'b10;
  localparam logic [1:0] M2R_ALU = 2'b00, M2R_MDR = 2'b01, M2R_PC = 2'b10;
  localparam logic [1:0] SRCB_B = 2'b00, SRCB_4 = 2'b01, SRCB_IMM = 2'b10, SRCB_SHIMM = 2'b11;

  typedef struct packed {
    logic [1:0] reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic       i_or_d;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       pc_write;
    logic [1:0] mem_to_reg;
    logic [1:0] pc_write_cond;
    logic [2:0] alu_op;
    logic [1:0] alu_src_b;
    logic [2:0] pc_source;
    logic       done;
  } ctrl_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Moore output decode: state (plus mem_ready for wait-state gating) to datapath controls.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  state_e state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  // Without wait states every access completes in its own cycle.
  logic ready;
  assign ready = mem_ready || !MEM_WAIT_EN;

  always_comb begin
    ctrl = '0;
    case (state)
      S_RESET:  begin ctrl.pc_write = 1'b1; ctrl.pc_source = PC_RSTV; end
      S_IF: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = ready;
        ctrl.pc_write  = ready;
        ctrl.alu_src_b = SRCB_4;
        ctrl.alu_op    = ALU_ADD;
      end
      S_ID:     ctrl.alu_src_b = SRCB_SHIMM;
      S_MEM_RD: begin ctrl.i_or_d = 1'b1; ctrl.mem_read = 1'b1; end
      S_WB_LS:  begin ctrl.reg_write = 1'b1; ctrl.mem_to_reg = M2R_MDR; ctrl.done = 1'b1; end
      S_MEM_ST: begin ctrl.i_or_d = 1'b1; ctrl.mem_write = 1'b1; ctrl.done = ready; end
      S_EX_R:   begin ctrl.alu_src_a = 1'b1; ctrl.alu_op = ALU_FUNCT; end
      S_WB_R:   begin ctrl.reg_dst = RD_RD; ctrl.reg_write = 1'b1; ctrl.done = 1'b1; end
      S_EX_ADDI, S_EX_ANDI, S_EX_ORI, S_EX_SLTI, S_EX_LUI: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        case (state)
          S_EX_ANDI: ctrl.alu_op = ALU_AND;
          S_EX_ORI:  ctrl.alu_op = ALU_OR;
          S_EX_SLTI: ctrl.alu_op = ALU_SLT;
          S_EX_LUI:  ctrl.alu_op = ALU_LUI;
          default:   ctrl.alu_op = ALU_ADD;
        endcase
      end
      S_WB_I:   begin ctrl.reg_write = 1'b1; ctrl.reg_dst = RD_RT; ctrl.done = 1'b1; end
      S_BEQ, S_BNE: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = (state == S_BEQ) ? 2'b01 : 2'b10;
        ctrl.pc_source     = PC_ALUOUT;
        ctrl.done          = 1'b1;
      end
      S_J:      begin ctrl.pc_write = 1'b1; ctrl.pc_source = PC_JUMP; ctrl.done = 1'b1; end
      S_JAL_WB: begin ctrl.reg_dst = RD_RA; ctrl.mem_to_reg = M2R_PC; ctrl.reg_write = 1'b1; end
      S_JR:     begin ctrl.pc_write = 1'b1; ctrl.pc_source = PC_REGA; ctrl.done = 1'b1; end
      default:  ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_v2.sv
// Multi-cycle MIPS controller: state register, dispatch, trap flag and retire counter.
// MC_CTRL_MEM_WAIT_EN makes IF/MEM_RD/MEM_ST wait for mem_ready.
module mc_ctrl_v2
  import mc_ctrl_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int OP_W  = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OP_W-1:0]  OP,
  input  logic [OP_W-1:0]  funct,
  input  logic             mem_ready,
  output logic [1:0]       RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic             IorD,
  output logic             IRWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             PCWrite,
  output logic [1:0]       MemtoReg,
  output logic [1:0]       PCWriteCond,
  output logic [2:0]       ALUOp,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       PCSource,
  output logic [4:0]       state,
  output logic             instr_done,
  output logic             illegal_op,
  output logic [CNT_W-1:0] retired
);

  state_e st, nxt;
  ctrl_t  ctrl;
  logic   hold;

  assign hold = MEM_WAIT_EN && !mem_ready;

  always_comb begin
    nxt = S_IF;
    case (st)
      S_IF:     nxt = hold ? S_IF : S_ID;
      S_ID: begin
        case (OP)
          OP_W'(OP_RTYPE): nxt = (funct == OP_W'(FN_JR)) ? S_JR : S_EX_R;
          OP_W'(OP_LW), OP_W'(OP_SW): nxt = S_EX_LS;
          OP_W'(OP_BEQ):   nxt = S_BEQ;
          OP_W'(OP_BNE):   nxt = S_BNE;
          OP_W'(OP_J):     nxt = S_J;
          OP_W'(OP_JAL):   nxt = S_JAL_WB;
          OP_W'(OP_ADDI):  nxt = S_EX_ADDI;
          OP_W'(OP_ANDI):  nxt = S_EX_ANDI;
          OP_W'(OP_ORI):   nxt = S_EX_ORI;
          OP_W'(OP_SLTI):  nxt = S_EX_SLTI;
          OP_W'(OP_LUI):   nxt = S_EX_LUI;
          default:         nxt = S_TRAP;
        endcase
      end
      S_EX_LS:  nxt = (OP == OP_W'(OP_LW)) ? S_MEM_RD : S_MEM_ST;
      S_MEM_RD: nxt = hold ? S_MEM_RD : S_WB_LS;
      S_MEM_ST: nxt = hold ? S_MEM_ST : S_IF;
      S_EX_R:   nxt = S_WB_R;
      S_EX_ADDI, S_EX_ANDI, S_EX_ORI, S_EX_SLTI, S_EX_LUI: nxt = S_WB_I;
      S_JAL_WB: nxt = S_J;
      S_TRAP:   nxt = S_TRAP;
      default:  nxt = S_IF;
    endcase
  end

  // Reset wins over everything, including a pending retire and the trap hold.
  always_ff @(posedge clk) begin
    if (!rst) begin
      st         <= S_RESET;
      illegal_op <= 1'b0;
      retired    <= '0;
    end else begin
      st <= nxt;
      if (nxt == S_TRAP) illegal_op <= 1'b1;
      if (ctrl.done)     retired    <= retired + CNT_W'(1);
    end
  end

  mc_ctrl_decode u_decode (
    .state     (st),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  assign state       = st;
  assign RegDst      = ctrl.reg_dst;
  assign RegWrite    = ctrl.reg_write;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign IorD        = ctrl.i_or_d;
  assign IRWrite     = ctrl.ir_write;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign PCWrite     = ctrl.pc_write;
  assign MemtoReg    = ctrl.mem_to_reg;
  assign PCWriteCond = ctrl.pc_write_cond;
  assign ALUOp       = ctrl.alu_op;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign PCSource    = ctrl.pc_source;
  assign instr_done  = ctrl.done;

endmodule
